rx_frame_loader: RTL and testbench

Receive-side frame controller between the UART byte receiver and the image memory used by the chain-code engine. It watches the receiver's byte/ready outputs and parses a framed image: sync byte, width, height, W×H pixel bytes, then an XOR checksum. It writes pixels into image RAM and holds a validated frame for the downstream engine until that engine acknowledges it.

---
 rtl/rx_frame_loader.sv | 133 +++++++++++++
 tb/tb_rx_frame_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_loader.sv
// rx_frame_loader: parses sync/width/height/pixels/XOR-checksum frames from a UART byte stream into image RAM
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   rx_data, rx_ready          byte and ready level from the UART receiver
//   mem_we, mem_addr, mem_wdata  image RAM write port, one strobe per pixel
//   img_width, img_height      dimensions of the last accepted header
//   frame_valid, frame_ack     validated frame handshake with the consumer
//   frame_err, err_code        abort pulse and held reason (1 checksum, 2 zero dim, 3 timeout)
//   overrun                    sticky: a byte arrived while a frame was held
//   busy                       registered "not idle"
module rx_frame_loader #(
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        img_width,
  output logic [7:0]        img_height,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              overrun,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, WIDTH, HEIGHT, PIXELS, CHECK, DONE} state_t;
  state_t      state_q;
  logic        rdy_q;
  logic [7:0]  chk_q;
  logic [15:0] pix_q;
  logic [15:0] total_q;
  logic [31:0] idle_q;
  logic        stb;
  logic        timing;
  // rdy_q resets high so a ready level already high at reset is not a byte
  assign stb    = rx_ready && !rdy_q;
  assign timing = TIMEOUT_CYC != 0 && state_q != IDLE && state_q != DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      chk_q       <= '0;
      pix_q       <= '0;
      total_q     <= '0;
      idle_q      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      img_width   <= '0;
      img_height  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rdy_q     <= rx_ready;
      mem_we    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= state_q != IDLE;
      // idle_q counts cycles elapsed since the last strobe, the strobe cycle being the first
      if (stb) idle_q <= 32'd1;
      case (state_q)
        IDLE: if (stb && rx_data == SYNC_BYTE) begin
          chk_q   <= '0;
          pix_q   <= '0;
          state_q <= WIDTH;
        end
        WIDTH: if (stb) begin
          img_width <= rx_data;
          chk_q     <= chk_q ^ rx_data;
          state_q   <= HEIGHT;
        end
        HEIGHT: if (stb) begin
          img_height <= rx_data;
          chk_q      <= chk_q ^ rx_data;
          total_q    <= {8'd0, img_width} * {8'd0, rx_data};
          if (img_width == 8'd0 || rx_data == 8'd0) begin
            frame_err <= 1'b1;
            err_code  <= 2'd2;
            state_q   <= IDLE;
          end else begin
            state_q <= PIXELS;
          end
        end
        PIXELS: if (stb) begin
          mem_we    <= 1'b1;
          mem_addr  <= ADDR_W'(pix_q);
          mem_wdata <= rx_data;
          chk_q     <= chk_q ^ rx_data;
          pix_q     <= pix_q + 16'd1;
          if (pix_q == total_q - 16'd1) state_q <= CHECK;
        end
        CHECK: if (stb) begin
          if (rx_data == chk_q) begin
            frame_valid <= 1'b1;
            state_q     <= DONE;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'd1;
            state_q   <= IDLE;
          end
        end
        DONE: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            state_q     <= IDLE;
          end else if (stb) begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // a strobe on the timeout cycle wins, so the check only runs without one
      if (timing && !stb) begin
        if (idle_q >= 32'(TIMEOUT_CYC - 1)) begin
          frame_err <= 1'b1;
          err_code  <= 2'd3;
          state_q   <= IDLE;
        end else begin
          idle_q <= idle_q + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_frame_loader.sv
// tb_rx_frame_loader: scoreboard bench for rx_frame_loader
module tb_rx_frame_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'hA5;
  logic        rx_ready = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  img_width;
  logic [7:0]  img_height;
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        overrun;
  logic        busy;
  int          tests = 0;
  int          fails = 0;
  logic [23:0] sb[$];
  logic        we_prev = 1'b0;
  rx_frame_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .img_width(img_width), .img_height(img_height),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          fails++;
          $display("FAIL write got=%0h/%0h exp=%0h/%0h", mem_addr, mem_wdata, e[23:8], e[7:0]);
        end
      end
      if (we_prev) begin
        fails++;
        $display("FAIL we_back_to_back consecutive mem_we cycles");
      end
    end
    we_prev = mem_we;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data = b;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] seed, input bit bad);
    logic [7:0] c;
    logic [7:0] p;
    c = w ^ h;
    send(8'hA5);
    send(w);
    send(h);
    for (int i = 0; i < int'(w) * int'(h); i++) begin
      p = seed + 8'(i * 16);
      sb.push_back({16'(i), p});
      c = c ^ p;
      send(p);
    end
    send(bad ? c ^ 8'h01 : c);
  endtask
  task automatic ack_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL ack_valid got=%b exp=0", frame_valid);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ack_busy got=%b exp=0", busy);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    tests++;
    if ({mem_we, mem_addr, mem_wdata, img_width, img_height, frame_valid, frame_err, err_code, overrun, busy} !== 46'd0) begin
      fails++;
      $display("FAIL %s_outputs we=%b a=%0h d=%0h w=%0h h=%0h v=%b e=%b c=%0d o=%b b=%b exp all 0",
               tag, mem_we, mem_addr, mem_wdata, img_width, img_height, frame_valid, frame_err, err_code, overrun, busy);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
  endtask
  task automatic test_good_frame();
    frame(8'd2, 8'd2, 8'h10, 1'b0);
    tests++;
    if (frame_valid !== 1'b1 || img_width !== 8'd2 || img_height !== 8'd2) begin
      fails++;
      $display("FAIL good_frame valid=%b w=%0d h=%0d exp 1/2/2", frame_valid, img_width, img_height);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL good_writes pending=%0d exp=0", sb.size());
    end
    ack_frame();
  endtask
  task automatic test_bad_checksum();
    frame(8'd2, 8'd2, 8'h10, 1'b1);
    tests++;
    if (frame_err !== 1'b1 || err_code !== 2'd1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL bad_chk err=%b code=%0d valid=%b exp 1/1/0", frame_err, err_code, frame_valid);
    end
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b0 || err_code !== 2'd1) begin
      fails++;
      $display("FAIL bad_chk_pulse err=%b code=%0d exp 0/1", frame_err, err_code);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL bad_chk_idle busy=%b valid=%b exp 0/0", busy, frame_valid);
    end
    test_good_frame();
  endtask
  task automatic test_zero_dim();
    send(8'h00);
    send(8'hFF);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL junk_busy got=%b exp=0", busy);
    end
    send(8'hA5);
    send(8'h00);
    send(8'h05);
    tests++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || img_height !== 8'd5 || img_width !== 8'd0) begin
      fails++;
      $display("FAIL zero_dim err=%b code=%0d w=%0d h=%0d exp 1/2/0/5", frame_err, err_code, img_width, img_height);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_dim_idle err=%b busy=%b exp 0/0", frame_err, busy);
    end
  endtask
  task automatic test_timeout();
    int n;
    n = -1;
    send(8'hA5);
    send(8'h03);
    for (int k = 0; k < 40 && n < 0; k++) begin
      if (frame_err === 1'b1) n = k;
      else @(negedge clk);
    end
    tests++;
    if (n != 15 || err_code !== 2'd3) begin
      fails++;
      $display("FAIL timeout delay=%0d code=%0d exp 15/3", n, err_code);
    end
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse got=%b exp=0", frame_err);
    end
  endtask
  task automatic test_overrun();
    frame(8'd1, 8'd3, 8'h21, 1'b0);
    tests++;
    if (frame_valid !== 1'b1 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre valid=%b ovr=%b exp 1/0", frame_valid, overrun);
    end
    send(8'h55);
    tests++;
    if (overrun !== 1'b1 || frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set ovr=%b valid=%b exp 1/1", overrun, frame_valid);
    end
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    tests++;
    if (overrun !== 1'b0 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear ovr=%b valid=%b exp 0/0", overrun, frame_valid);
    end
  endtask
  task automatic test_reset_mid_frame();
    send(8'hA5);
    send(8'h04);
    send(8'h04);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({16'(i), 8'(8'h80 + i)});
      send(8'(8'h80 + i));
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    frame(8'd3, 8'd5, 8'h07, 1'b0);
    tests++;
    if (frame_valid !== 1'b1 || img_width !== 8'd3 || img_height !== 8'd5 || sb.size() != 0) begin
      fails++;
      $display("FAIL fresh_frame valid=%b w=%0d h=%0d pending=%0d exp 1/3/5/0", frame_valid, img_width, img_height, sb.size());
    end
    ack_frame();
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_dim();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
